id_ex_stage: RTL

Registered operand-issue stage between instruction decode and the 32-bit combinational ALU. It accepts decoded operations over a valid/ready handshake and holds them in a 2-entry buffer. It patches stale register operands with forwarded writeback data, selects the immediate, and presents `a`, `b` and `op` ready for the ALU to consume. The 2-entry buffer absorbs one cycle of downstream stall without dropping or duplicating an operation.

---
 rtl/id_ex_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: operand-issue stage between decode and the 32-bit ALU.
// Holds up to two decoded ops (head/tail) behind a valid/ready handshake,
// selects the immediate for b and patches stale register operands with
// writeback data, then presents a/b/op/rd from the head entry.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   decode-side handshake (in_ready depends on state only)
//   in_rs1_val, in_rs2_val, in_rs1, in_rs2, in_imm, in_use_imm, in_op, in_rd
//                         decoded operation fields
//   fwd_en, fwd_rd, fwd_data
//                         writeback result retiring this cycle
//   out_valid / out_ready ALU-side handshake
//   out_a, out_b, out_op, out_rd
//                         head entry contents
//
// Build option: define ID_EX_FWD_EN to enable writeback forwarding. When it is
// undefined the fwd_* ports are present but ignored and no comparators exist.
module id_ex_stage #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_rs1_val,
    input  logic [W-1:0] in_rs2_val,
    input  logic [4:0]   in_rs1,
    input  logic [4:0]   in_rs2,
    input  logic [W-1:0] in_imm,
    input  logic         in_use_imm,
    input  logic [2:0]   in_op,
    input  logic [4:0]   in_rd,
    input  logic         fwd_en,
    input  logic [4:0]   fwd_rd,
    input  logic [W-1:0] fwd_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b,
    output logic [2:0]   out_op,
    output logic [4:0]   out_rd
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned OP_W  = 3;

    typedef struct packed {
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             b_is_reg;
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rd;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nx;
    entry_t head, tail;
    entry_t new_e, head_p, tail_p;
    logic   push, pop;

    // Handshake decode is a function of occupancy only.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_a  = head.a;
    assign out_b  = head.b;
    assign out_op = head.op;
    assign out_rd = head.rd;

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Occupancy next-state.
    always_comb begin
        state_nx = state;
        case (state)
            EMPTY: if (push) state_nx = ONE;
            ONE: begin
                if (push && !pop)      state_nx = FULL;
                else if (pop && !push) state_nx = EMPTY;
            end
            FULL:  if (pop) state_nx = ONE;
            default: state_nx = EMPTY;
        endcase
    end

    // Incoming entry capture and forward patching of incoming/stored operands.
    always_comb begin
        new_e.a        = in_rs1_val;
        new_e.b        = in_use_imm ? in_imm : in_rs2_val;
        new_e.rs1      = in_rs1;
        new_e.rs2      = in_rs2;
        new_e.b_is_reg = !in_use_imm;
        new_e.op       = in_op;
        new_e.rd       = in_rd;
        head_p         = head;
        tail_p         = tail;
`ifdef ID_EX_FWD_EN
        // x0 is never forwarded; immediates are never overwritten.
        if (fwd_en && (fwd_rd != 5'd0)) begin
            if (fwd_rd == in_rs1)                 new_e.a  = fwd_data;
            if (!in_use_imm && fwd_rd == in_rs2)  new_e.b  = fwd_data;
            if (fwd_rd == head.rs1)               head_p.a = fwd_data;
            if (head.b_is_reg && fwd_rd == head.rs2) head_p.b = fwd_data;
            if (fwd_rd == tail.rs1)               tail_p.a = fwd_data;
            if (tail.b_is_reg && fwd_rd == tail.rs2) tail_p.b = fwd_data;
        end
`endif
    end

`ifndef ID_EX_FWD_EN
    // Forward inputs and head source-index fields have no consumer here.
    logic unused_fwd;
    assign unused_fwd = ^{fwd_en, fwd_rd, fwd_data, head.rs1, head.rs2, head.b_is_reg};
`endif

    // Entry storage; stored entries always take their patched value.
    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head_p;
            tail <= tail_p;
            case (state)
                EMPTY: if (push) head <= new_e;
                ONE: begin
                    if (push && pop) head <= new_e;
                    else if (push)   tail <= new_e;
                end
                FULL:  if (pop) head <= tail_p;
                default: ;
            endcase
        end
    end

endmodule
